// File: rtl/booth_ctrl_if.sv
// Handshake/control bundle between the ALU top level, the Booth datapath and booth_ctrl.
// Optional abort input exists only when BOOTH_CTRL_ABORT_EN is defined.
interface booth_ctrl_if;
    logic       start;
`ifdef BOOTH_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       q0;
    logic       q_m1;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    logic       c5;
    logic       c6;
    logic       busy;
    logic       done;
    logic [3:0] dbg_state;

    // Handshake: start is a request level sampled only while busy=0;
    // done is a one-cycle pulse and busy falls on the cycle after it.
    modport master (
        output start,
`ifdef BOOTH_CTRL_ABORT_EN
        output abort,
`endif
        output q0, q_m1,
        input  c0, c1, c2, c3, c4, c5, c6, busy, done, dbg_state
    );

    modport slave (
        input  start,
`ifdef BOOTH_CTRL_ABORT_EN
        input  abort,
`endif
        input  q0, q_m1,
        output c0, c1, c2, c3, c4, c5, c6, busy, done, dbg_state
    );
endinterface

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: Moore FSM with registered c0..c6/busy/done strobes.
// Define BOOTH_CTRL_ABORT_EN to add the abort input that returns any busy state to IDLE.
module booth_ctrl #(
    parameter  int w     = 16,
    localparam int CNT_W = $clog2(w) + 1
) (
    input logic          clk,
    input logic          rst_b,
    booth_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_Q = 4'd1,
        S_LOAD_M = 4'd2,
        S_TEST   = 4'd3,
        S_ADD    = 4'd4,
        S_SUB    = 4'd5,
        S_SHIFT  = 4'd6,
        S_OUT_A  = 4'd7,
        S_OUT_Q  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // {busy, done, c6, c5, c4, c3, c2, c1, c0}
    logic [8:0]         ctrl_q;

    function automatic logic [8:0] decode(input state_t s);
        logic [8:0] v;
        v = 9'h000;
        case (s)
            S_LOAD_Q: v = 9'h101;
            S_LOAD_M: v = 9'h102;
            S_TEST:   v = 9'h100;
            S_ADD:    v = 9'h104;
            S_SUB:    v = 9'h10C;
            S_SHIFT:  v = 9'h110;
            S_OUT_A:  v = 9'h120;
            S_OUT_Q:  v = 9'h140;
            S_DONE:   v = 9'h180;
            default:  v = 9'h000;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD_Q;
            S_LOAD_Q: begin
                cnt_d   = '0;
                state_d = S_LOAD_M;
            end
            S_LOAD_M: state_d = S_TEST;
            S_TEST: begin
                case ({bus.q0, bus.q_m1})
                    2'b10:   state_d = S_SUB;
                    2'b01:   state_d = S_ADD;
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD:    state_d = S_SHIFT;
            S_SUB:    state_d = S_SHIFT;
            // Compare the pre-increment count so exactly w shifts occur.
            S_SHIFT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(w - 1)) ? S_OUT_A : S_TEST;
            end
            S_OUT_A:  state_d = S_OUT_Q;
            S_OUT_Q:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef BOOTH_CTRL_ABORT_EN
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    // Strobes are decoded from the next state so they register in step with state_q.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= decode(state_d);
        end
    end

    assign bus.c0        = ctrl_q[0];
    assign bus.c1        = ctrl_q[1];
    assign bus.c2        = ctrl_q[2];
    assign bus.c3        = ctrl_q[3];
    assign bus.c4        = ctrl_q[4];
    assign bus.c5        = ctrl_q[5];
    assign bus.c6        = ctrl_q[6];
    assign bus.done      = ctrl_q[7];
    assign bus.busy      = ctrl_q[8];
    assign bus.dbg_state = state_q;

endmodule
